pipe_elastic_reg: RTL and testbench

PIPE_ELASTIC_REG -- requirements
Module: pipe_elastic_reg

---
 rtl/pipe_pkg.sv | 16 +
 rtl/pipe_elastic_reg_ring_ptr.sv | 36 +++
 rtl/pipe_elastic_reg.sv | 91 +++++++++
 tb/tb_pipe_elastic_reg.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and width helpers for the pipeline stage registers.
package pipe_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_DEPTH = 2;

  // Occupancy must represent 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_elastic_reg_ring_ptr.sv
// Modulo-DEPTH pointer with clear and increment; wraps correctly for any DEPTH.
module ring_ptr
  import pipe_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned PW    = ptr_width(DEFAULT_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  localparam logic [PW-1:0] LAST_C = PW'(DEPTH - 1);

  logic [PW-1:0] ptr_r;

  // Pointer state: clear wins over increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_r <= {PW{1'b0}};
    end else if (clr) begin
      ptr_r <= {PW{1'b0}};
    end else if (inc) begin
      if (ptr_r == LAST_C) begin
        ptr_r <= {PW{1'b0}};
      end else begin
        ptr_r <= ptr_r + PW'(1);
      end
    end
  end

  assign ptr = ptr_r;

endmodule

// File: rtl/pipe_elastic_reg.sv
// Elastic pipeline register: DEPTH-entry in-order ring buffer with flush.
module pipe_elastic_reg
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [cnt_width(DEPTH)-1:0]  count
);

  localparam int unsigned   CW     = cnt_width(DEPTH);
  localparam int unsigned   PW     = ptr_width(DEPTH);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_nxt_s;
  logic [PW-1:0]    rd_ptr_s;
  logic [PW-1:0]    wr_ptr_s;
  logic             push_s;
  logic             pop_s;

  // Handshake flags come only from registered occupancy, never from the peer's strobe.
  assign in_ready  = (count_r < FULL_C);
  assign out_valid = (count_r != {CW{1'b0}});
  assign out_data  = mem_r[rd_ptr_s];
  assign count     = count_r;

  assign push_s = in_valid && in_ready && !flush;
  assign pop_s  = out_valid && out_ready && !flush;

  ring_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (pop_s),
    .ptr (rd_ptr_s)
  );

  ring_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (push_s),
    .ptr (wr_ptr_s)
  );

  // Next occupancy: flush empties, simultaneous push/pop holds.
  always_comb begin
    count_nxt_s = count_r;
    if (flush) begin
      count_nxt_s = {CW{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_nxt_s = count_r + CW'(1);
        2'b01:   count_nxt_s = count_r - CW'(1);
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= {CW{1'b0}};
    end else begin
      count_r <= count_nxt_s;
    end
  end

  // Flop storage; flush leaves contents in place since the pointers make them unreachable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (push_s) begin
      mem_r[wr_ptr_s] <= in_data;
    end
  end

endmodule

// File: tb/tb_pipe_elastic_reg.sv
// Directed and randomized checks of pipe_elastic_reg at DEPTH 1..4 (WIDTH 32).
module tb_pipe_elastic_reg;

  logic        clk;
  logic        rst;
  logic [3:0]  flush;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] in_data  [4];
  logic [31:0] out_data [4];
  logic [2:0]  cnt      [4];

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int D  = g + 1;
    localparam int CW = $clog2(D + 1);
    logic [CW-1:0] c_s;
    pipe_elastic_reg #(.WIDTH(32), .DEPTH(D)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .count     (c_s)
    );
    assign cnt[g] = 3'(c_s);
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    flush = 4'b0; in_valid = 4'b0; out_ready = 4'b0;
    for (int i = 0; i < 4; i++) in_data[i] = 32'h0;
    #1;
    total++; if (in_ready[1] !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready[1]); end
    total++; if (out_valid[1] !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid[1]); end
    total++; if (out_data[1] !== 32'h0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", out_data[1]); end
    total++; if (cnt[1] !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", cnt[1]); end
    #11;
    rst = 1'b1;
  endtask

  task automatic test_single_push();
    in_valid[1] = 1'b1; in_data[1] = 32'hA; out_ready[1] = 1'b0;
    edge1();
    in_valid[1] = 1'b0;
    total++; if (out_valid[1] !== 1'b1) begin bad++; $display("FAIL single_out_valid got=%b exp=1", out_valid[1]); end
    total++; if (out_data[1] !== 32'hA) begin bad++; $display("FAIL single_out_data got=%h exp=a", out_data[1]); end
    total++; if (cnt[1] !== 3'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", cnt[1]); end
    total++; if (in_ready[1] !== 1'b1) begin bad++; $display("FAIL single_in_ready got=%b exp=1", in_ready[1]); end
    out_ready[1] = 1'b1;
    edge1();
    out_ready[1] = 1'b0;
    total++; if (cnt[1] !== 3'd0) begin bad++; $display("FAIL single_drain got=%0d exp=0", cnt[1]); end
  endtask

  task automatic test_fill();
    in_valid[1] = 1'b1;
    in_data[1] = 32'h1; edge1();
    in_data[1] = 32'h2; edge1();
    in_data[1] = 32'h3;
    total++; if (in_ready[1] !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%b exp=0", in_ready[1]); end
    edge1();
    in_valid[1] = 1'b0;
    total++; if (cnt[1] !== 3'd2) begin bad++; $display("FAIL full_count got=%0d exp=2", cnt[1]); end
    total++; if (out_data[1] !== 32'h1) begin bad++; $display("FAIL fill_first got=%h exp=1", out_data[1]); end
    out_ready[1] = 1'b1;
    edge1();
    total++; if (out_data[1] !== 32'h2) begin bad++; $display("FAIL fill_second got=%h exp=2", out_data[1]); end
    total++; if (cnt[1] !== 3'd1) begin bad++; $display("FAIL fill_pop_count got=%0d exp=1", cnt[1]); end
    total++; if (in_ready[1] !== 1'b1) begin bad++; $display("FAIL fill_ready_after_pop got=%b exp=1", in_ready[1]); end
    edge1();
    out_ready[1] = 1'b0;
    total++; if (cnt[1] !== 3'd0 || out_valid[1] !== 1'b0) begin bad++; $display("FAIL fill_empty count=%0d valid=%b exp=0/0", cnt[1], out_valid[1]); end
  endtask

  task automatic test_wrap();
    in_valid[2] = 1'b1; in_data[2] = 32'd0; out_ready[2] = 1'b0;
    edge1();
    for (int k = 1; k <= 9; k++) begin
      in_data[2] = 32'(k); out_ready[2] = 1'b1;
      total++; if (out_data[2] !== 32'(k - 1)) begin bad++; $display("FAIL wrap_data got=%0d exp=%0d", out_data[2], k - 1); end
      total++; if (cnt[2] !== 3'd1) begin bad++; $display("FAIL wrap_count got=%0d exp=1", cnt[2]); end
      edge1();
    end
    in_valid[2] = 1'b0;
    total++; if (out_data[2] !== 32'd9 || cnt[2] !== 3'd1) begin bad++; $display("FAIL wrap_last data=%0d count=%0d exp=9/1", out_data[2], cnt[2]); end
    edge1();
    out_ready[2] = 1'b0;
    total++; if (cnt[2] !== 3'd0) begin bad++; $display("FAIL wrap_drain got=%0d exp=0", cnt[2]); end
  endtask

  task automatic test_flush();
    in_valid[1] = 1'b1;
    in_data[1] = 32'h5; edge1();
    in_data[1] = 32'h6; edge1();
    in_data[1] = 32'h7; flush[1] = 1'b1; out_ready[1] = 1'b1;
    edge1();
    flush[1] = 1'b0; in_valid[1] = 1'b0; out_ready[1] = 1'b0;
    total++; if (cnt[1] !== 3'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", cnt[1]); end
    total++; if (out_valid[1] !== 1'b0) begin bad++; $display("FAIL flush_out_valid got=%b exp=0", out_valid[1]); end
    total++; if (in_ready[1] !== 1'b1) begin bad++; $display("FAIL flush_in_ready got=%b exp=1", in_ready[1]); end
    in_valid[1] = 1'b1; in_data[1] = 32'h8;
    edge1();
    total++; if (out_data[1] !== 32'h8 || cnt[1] !== 3'd1) begin bad++; $display("FAIL flush_repush data=%h count=%0d exp=8/1", out_data[1], cnt[1]); end
    // Flush with room available must still not store the offered word.
    in_data[1] = 32'h9; flush[1] = 1'b1;
    edge1();
    flush[1] = 1'b0; in_valid[1] = 1'b0;
    total++; if (cnt[1] !== 3'd0 || out_valid[1] !== 1'b0) begin bad++; $display("FAIL flush_partial count=%0d valid=%b exp=0/0", cnt[1], out_valid[1]); end
  endtask

  task automatic test_async_reset();
    in_valid[1] = 1'b1;
    in_data[1] = 32'h11; edge1();
    in_data[1] = 32'h22; edge1();
    in_valid[1] = 1'b0;
    total++; if (cnt[1] !== 3'd2) begin bad++; $display("FAIL arst_pre_count got=%0d exp=2", cnt[1]); end
    #2 rst = 1'b0;
    #1;
    total++; if (cnt[1] !== 3'd0) begin bad++; $display("FAIL arst_count got=%0d exp=0", cnt[1]); end
    total++; if (out_valid[1] !== 1'b0) begin bad++; $display("FAIL arst_out_valid got=%b exp=0", out_valid[1]); end
    total++; if (out_data[1] !== 32'h0) begin bad++; $display("FAIL arst_out_data got=%h exp=0", out_data[1]); end
    #2 rst = 1'b1;
    in_valid[1] = 1'b1; in_data[1] = 32'h33;
    edge1();
    in_valid[1] = 1'b0;
    total++; if (out_data[1] !== 32'h33 || cnt[1] !== 3'd1) begin bad++; $display("FAIL arst_repush data=%h count=%0d exp=33/1", out_data[1], cnt[1]); end
    out_ready[1] = 1'b1;
    edge1();
    out_ready[1] = 1'b0;
  endtask

  task automatic test_random(input int i);
    logic [31:0] q[$];
    int depth;
    int sz;
    depth = i + 1;
    q.delete();
    for (int c = 0; c < 2500; c++) begin
      in_valid[i]  = 1'($urandom_range(0, 1));
      out_ready[i] = 1'($urandom_range(0, 1));
      in_data[i]   = $urandom;
      sz = q.size();
      total++; if (cnt[i] !== 3'(sz)) begin bad++; $display("FAIL rand_count d=%0d got=%0d exp=%0d", depth, cnt[i], sz); end
      total++; if (in_ready[i] !== (sz < depth)) begin bad++; $display("FAIL rand_in_ready d=%0d got=%b exp=%b", depth, in_ready[i], sz < depth); end
      total++; if (out_valid[i] !== (sz != 0)) begin bad++; $display("FAIL rand_out_valid d=%0d got=%b exp=%b", depth, out_valid[i], sz != 0); end
      if (sz != 0 && out_ready[i]) begin
        total++; if (out_data[i] !== q[0]) begin bad++; $display("FAIL rand_data d=%0d got=%h exp=%h", depth, out_data[i], q[0]); end
        void'(q.pop_front());
      end
      if (in_valid[i] && sz < depth) q.push_back(in_data[i]);
      edge1();
    end
    in_valid[i] = 1'b0; out_ready[i] = 1'b0; flush[i] = 1'b1;
    edge1();
    flush[i] = 1'b0;
    total++; if (cnt[i] !== 3'd0) begin bad++; $display("FAIL rand_flush d=%0d got=%0d exp=0", depth, cnt[i]); end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_fill();
    test_wrap();
    test_flush();
    test_async_reset();
    for (int i = 0; i < 4; i++) test_random(i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
